// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Write port used by the seven-segment scan controller. One instance is used
// per writer.
//
// Signals:
//   valid  writer request; held with addr/data stable until ready is seen
//   addr   digit index, 0 = leftmost digit
//   data   digit code {blank, hex[3:0]}
//   ready  grant returned by the controller (combinational)
//
// Modports:
//   master  the application side that issues writes
//   slave   the controller side that grants and commits them
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if;
    logic       valid;
    logic [1:0] addr;
    logic [4:0] data;
    logic       ready;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Scan controller and write arbiter for a 4-digit multiplexed seven-segment
// display. A 4-entry store holds one code per digit ({blank, hex}). The scan
// FSM lights one digit at a time for 2**DIV_W clocks and inserts DEAD_CYC
// all-off clocks between digits. Two writers share the store through a
// round-robin arbiter that only rotates when both request together.
//
// Parameters:
//   DIV_W      dwell per digit is 2**DIV_W clocks
//   DEAD_CYC   all-anodes-off clocks between digits (0..255, 0 = no gap)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   p0, p1     write ports (slave side); p0 holds priority after reset
//   blank_all  forces dark outputs while the scan keeps running
//   num        segments {g,f,e,d,c,b,a}, active-low, registered
//   anode      digit enables, active-low, registered; digit i -> anode[3-i]
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIV_W    = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        p0,
    seg_scan_ctrl_if.slave        p1,
    input  logic                  blank_all,
    output logic [6:0]            num,
    output logic [3:0]            anode
);

    typedef enum logic [0:0] {
        ST_ON   = 1'b0,
        ST_DEAD = 1'b1
    } scan_state_t;

    localparam logic [DIV_W-1:0] DWELL_LAST = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DWELL_ONE  = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] DWELL_ZERO = {DIV_W{1'b0}};
    localparam bit               HAS_DEAD   = (DEAD_CYC > 0);
    // Only meaningful when HAS_DEAD; the DEAD state is unreachable otherwise.
    localparam logic [7:0]       DEAD_LAST  = HAS_DEAD ? 8'(DEAD_CYC - 1) : 8'd0;
    localparam logic [4:0]       CODE_BLANK = 5'b10000;
    localparam logic [6:0]       SEG_OFF    = 7'b1111111;
    localparam logic [3:0]       AN_OFF     = 4'b1111;

    // Active-low seven-segment decode; the blank bit overrides the hex value.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        if (code[4]) begin
            seg = SEG_OFF;
        end else begin
            case (code[3:0])
                4'h0:    seg = 7'b1000000;
                4'h1:    seg = 7'b1111001;
                4'h2:    seg = 7'b0100100;
                4'h3:    seg = 7'b0110000;
                4'h4:    seg = 7'b0011001;
                4'h5:    seg = 7'b0010010;
                4'h6:    seg = 7'b0000010;
                4'h7:    seg = 7'b1111000;
                4'h8:    seg = 7'b0000000;
                4'h9:    seg = 7'b0010000;
                4'hA:    seg = 7'b0001000;
                4'hB:    seg = 7'b0000011;
                4'hC:    seg = 7'b1000110;
                4'hD:    seg = 7'b0100001;
                4'hE:    seg = 7'b0000110;
                4'hF:    seg = 7'b0001110;
                default: seg = SEG_OFF;
            endcase
        end
        return seg;
    endfunction

    scan_state_t      state_r;
    scan_state_t      state_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_s;
    logic [DIV_W-1:0] dwell_r;
    logic [DIV_W-1:0] dwell_s;
    logic [7:0]       dead_r;
    logic [7:0]       dead_s;

    logic [4:0]       code_r [4];
    logic             prio_r;        // 0: p0 wins a tie, 1: p1 wins a tie
    logic             grant0_s;
    logic             grant1_s;
    logic             wr_en_s;
    logic [1:0]       wr_addr_s;
    logic [4:0]       wr_data_s;

    logic [3:0]       anode_s;
    logic [6:0]       num_s;
    logic [3:0]       anode_r;
    logic [6:0]       num_r;

    // Round-robin grant: a lone requester always wins, a tie goes to prio_r.
    always_comb begin
        grant0_s = p0.valid && (!p1.valid || !prio_r);
        grant1_s = p1.valid && (!p0.valid ||  prio_r);
    end

    assign p0.ready = grant0_s;
    assign p1.ready = grant1_s;

    // Select the single committing writer for this cycle.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 2'd0;
        wr_data_s = CODE_BLANK;
        if (grant0_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = p0.addr;
            wr_data_s = p0.data;
        end else if (grant1_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = p1.addr;
            wr_data_s = p1.data;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = 2'd0;
            wr_data_s = CODE_BLANK;
        end
    end

    // Priority flips only on a contested cycle so a lone writer never
    // steals the other's next turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (p0.valid && p1.valid) begin
            prio_r <= ~prio_r;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Digit store; every entry returns to blank on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                code_r[i] <= CODE_BLANK;
            end
        end else if (wr_en_s) begin
            code_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Scan FSM state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_ON;
            idx_r   <= 2'd0;
            dwell_r <= DWELL_ZERO;
            dead_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            dwell_r <= dwell_s;
            dead_r  <= dead_s;
        end
    end

    // Scan FSM next state: dwell on a digit, then either an all-off gap or a
    // direct step to the next digit when the gap length is zero.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        dwell_s = dwell_r;
        dead_s  = dead_r;
        case (state_r)
            ST_ON: begin
                if (dwell_r == DWELL_LAST) begin
                    dwell_s = DWELL_ZERO;
                    if (HAS_DEAD) begin
                        state_s = ST_DEAD;
                        dead_s  = 8'd0;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                    end
                end else begin
                    dwell_s = dwell_r + DWELL_ONE;
                end
            end
            ST_DEAD: begin
                if (dead_r == DEAD_LAST) begin
                    state_s = ST_ON;
                    idx_s   = idx_r + 2'd1;
                    dwell_s = DWELL_ZERO;
                end else begin
                    dead_s  = dead_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_ON;
                idx_s   = 2'd0;
                dwell_s = DWELL_ZERO;
                dead_s  = 8'd0;
            end
        endcase
    end

    // Pin values for the next edge. The store is read directly, so a commit
    // to the lit digit reaches num one clock after its commit edge.
    always_comb begin
        anode_s = AN_OFF;
        num_s   = SEG_OFF;
        if (blank_all) begin
            anode_s = AN_OFF;
            num_s   = SEG_OFF;
        end else if (state_r == ST_ON) begin
            anode_s = ~(4'b1000 >> idx_r);
            num_s   = seg_decode(code_r[idx_r]);
        end else begin
            anode_s = AN_OFF;
            num_s   = SEG_OFF;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_r <= AN_OFF;
            num_r   <= SEG_OFF;
        end else begin
            anode_r <= anode_s;
            num_r   <= num_s;
        end
    end

    assign anode = anode_r;
    assign num   = num_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl. Main instance uses DIV_W=3, DEAD_CYC=2
// (10 clocks per digit, 40 per scan); a second instance with DEAD_CYC=0
// (8 clocks per digit, no gap) runs alongside with writers idle.
// Expected pin values come from a cycle-count model of the scan and a local
// copy of the digit store updated from the hand-written write tables.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       blank_all;
    logic       blank_all0;
    logic [6:0] num;
    logic [6:0] num0;
    logic [3:0] anode;
    logic [3:0] anode0;

    int total = 0;
    int bad   = 0;
    int cyc;

    logic [4:0] exp_code [4];
    logic [6:0] seg_tab [16];
    logic [4:0] wr_vals [4];

    typedef struct {
        logic       v0;
        logic [1:0] a0;
        logic [4:0] d0;
        logic       v1;
        logic [1:0] a1;
        logic [4:0] d1;
        logic       r0;
        logic       r1;
    } arb_step_t;

    arb_step_t arb_tab [8];

    seg_scan_ctrl_if w0 ();
    seg_scan_ctrl_if w1 ();
    seg_scan_ctrl_if z0 ();
    seg_scan_ctrl_if z1 ();

    seg_scan_ctrl #(.DIV_W(3), .DEAD_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (w0),
        .p1        (w1),
        .blank_all (blank_all),
        .num       (num),
        .anode     (anode)
    );

    seg_scan_ctrl #(.DIV_W(3), .DEAD_CYC(0)) dut_nodead (
        .clk       (clk),
        .rst       (rst),
        .p0        (z0),
        .p1        (z1),
        .blank_all (blank_all0),
        .num       (num0),
        .anode     (anode0)
    );

    always #5 clk = ~clk;

    // Edges seen since reset was last released.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [4:0] c);
        if (c[4]) return 7'h7F;
        else      return seg_tab[c[3:0]];
    endfunction

    // Expected anode after n edges for a given dwell and gap length.
    function automatic logic [3:0] exp_an(input int n, input int dw, input int dc);
        int per, p, d, off;
        if (n == 0) return 4'hF;
        per = dw + dc;
        p   = (n - 1) % (4 * per);
        d   = p / per;
        off = p % per;
        if (off < dw) return ~(4'b1000 >> d);
        else          return 4'hF;
    endfunction

    function automatic logic [6:0] exp_nm(input int n);
        int p, d, off;
        if (n == 0) return 7'h7F;
        p   = (n - 1) % 40;
        d   = p / 10;
        off = p % 10;
        if (off < 8) return dec(exp_code[d]);
        else         return 7'h7F;
    endfunction

    function automatic int offs();
        return (cyc - 1) % 10;
    endfunction

    function automatic int cur_digit();
        return ((cyc - 1) % 40) / 10;
    endfunction

    task automatic step_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("anode", anode, exp_an(cyc, 8, 2));
            chk("num", num, exp_nm(cyc));
            chk("anode_nodead", anode0, exp_an(cyc, 8, 0));
            chk("num_nodead", num0, 7'h7F);
        end
    endtask

    task automatic wait_offs(input int o, input string tag);
        int found;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(negedge clk);
            if (offs() == o) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] old_num;
        int d;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        wr_vals = '{5'h04, 5'h08, 5'h09, 5'h01};
        arb_tab[0] = '{1'b1, 2'd0, 5'h0A, 1'b1, 2'd0, 5'h0C, 1'b1, 1'b0};
        arb_tab[1] = '{1'b1, 2'd1, 5'h0B, 1'b1, 2'd0, 5'h0C, 1'b0, 1'b1};
        arb_tab[2] = '{1'b1, 2'd1, 5'h0B, 1'b1, 2'd1, 5'h0D, 1'b1, 1'b0};
        arb_tab[3] = '{1'b1, 2'd2, 5'h0E, 1'b1, 2'd1, 5'h0D, 1'b0, 1'b1};
        arb_tab[4] = '{1'b1, 2'd2, 5'h0E, 1'b0, 2'd0, 5'h00, 1'b1, 1'b0};
        arb_tab[5] = '{1'b0, 2'd0, 5'h00, 1'b1, 2'd3, 5'h0F, 1'b0, 1'b1};
        arb_tab[6] = '{1'b1, 2'd3, 5'h05, 1'b1, 2'd2, 5'h06, 1'b1, 1'b0};
        arb_tab[7] = '{1'b0, 2'd0, 5'h00, 1'b1, 2'd2, 5'h06, 1'b0, 1'b1};

        rst = 1'b1; blank_all = 1'b0; blank_all0 = 1'b0;
        w0.valid = 1'b0; w0.addr = 2'd0; w0.data = 5'h00;
        w1.valid = 1'b0; w1.addr = 2'd0; w1.data = 5'h00;
        z0.valid = 1'b0; z0.addr = 2'd0; z0.data = 5'h00;
        z1.valid = 1'b0; z1.addr = 2'd0; z1.data = 5'h00;
        for (int i = 0; i < 4; i++) exp_code[i] = 5'h10;

        // 1. reset values, then a blank scan with gaps
        repeat (2) @(negedge clk);
        chk("rst_anode", anode, 4'hF);
        chk("rst_num", num, 7'h7F);
        chk("rst_anode_nodead", anode0, 4'hF);
        chk("rst_p0_ready_idle", w0.ready, 1'b0);
        rst = 1'b0;
        step_chk(42);

        // 2. back-to-back writes from p0 alone
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w0.valid = 1'b1; w0.addr = 2'(i); w0.data = wr_vals[i];
            #1;
            chk("p0_ready_alone", w0.ready, 1'b1);
            chk("p1_ready_idle", w1.ready, 1'b0);
            exp_code[i] = wr_vals[i];
        end
        @(negedge clk);
        w0.valid = 1'b0;
        step_chk(40);

        // 3. contested writes alternate; lone requesters granted at once
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w0.valid = arb_tab[i].v0; w0.addr = arb_tab[i].a0; w0.data = arb_tab[i].d0;
            w1.valid = arb_tab[i].v1; w1.addr = arb_tab[i].a1; w1.data = arb_tab[i].d1;
            #1;
            chk("arb_p0_ready", w0.ready, arb_tab[i].r0);
            chk("arb_p1_ready", w1.ready, arb_tab[i].r1);
            if (arb_tab[i].r0) exp_code[arb_tab[i].a0] = arb_tab[i].d0;
            if (arb_tab[i].r1) exp_code[arb_tab[i].a1] = arb_tab[i].d1;
        end
        @(negedge clk);
        w0.valid = 1'b0; w1.valid = 1'b0;
        step_chk(40);

        // 4. write to the lit digit: num follows one clock after commit
        wait_offs(1, "wait_lit_digit");
        d = cur_digit();
        old_num = num;
        w0.valid = 1'b1; w0.addr = 2'(d); w0.data = 5'h07;
        #1;
        chk("live_ready", w0.ready, 1'b1);
        @(negedge clk);
        w0.valid = 1'b0;
        chk("live_commit_edge", num, old_num);
        exp_code[d] = 5'h07;
        @(negedge clk);
        chk("live_next_edge", num, 7'b1111000);
        w0.valid = 1'b1; w0.addr = 2'(d); w0.data = 5'b1_0101;
        @(negedge clk);
        w0.valid = 1'b0;
        chk("blank_commit_edge", num, 7'b1111000);
        exp_code[d] = 5'b1_0101;
        @(negedge clk);
        chk("blank_code", num, 7'h7F);
        chk("blank_code_anode", anode, exp_an(cyc, 8, 2));

        // 5. blank_all for 5 clocks mid-dwell, with a write accepted meanwhile
        wait_offs(1, "wait_mid_dwell");
        d = cur_digit();
        blank_all = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("blank_all_anode", anode, 4'hF);
            chk("blank_all_num", num, 7'h7F);
            if (i == 1) begin
                w0.valid = 1'b1; w0.addr = 2'((d + 1) % 4); w0.data = 5'h09;
                #1;
                chk("blank_all_ready", w0.ready, 1'b1);
                exp_code[(d + 1) % 4] = 5'h09;
            end else begin
                w0.valid = 1'b0;
            end
            if (i == 5) blank_all = 1'b0;
        end
        step_chk(40);

        // 6. reset in the gap with p1 requesting
        wait_offs(8, "wait_dead");
        w1.valid = 1'b1; w1.addr = 2'd0; w1.data = 5'h03;
        #1;
        chk("dead_p1_ready", w1.ready, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_anode", anode, 4'hF);
        chk("async_rst_num", num, 7'h7F);
        chk("async_rst_anode_nodead", anode0, 4'hF);
        @(negedge clk);
        chk("held_rst_anode", anode, 4'hF);
        w1.valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_code[i] = 5'h10;
        step_chk(42);

        // priority is back on p0 after reset
        @(negedge clk);
        w0.valid = 1'b1; w0.addr = 2'd1; w0.data = 5'h02;
        w1.valid = 1'b1; w1.addr = 2'd2; w1.data = 5'h03;
        #1;
        chk("post_rst_p0_ready", w0.ready, 1'b1);
        chk("post_rst_p1_ready", w1.ready, 1'b0);
        exp_code[1] = 5'h02;
        @(negedge clk);
        w0.valid = 1'b0;
        #1;
        chk("post_rst_p1_alone", w1.ready, 1'b1);
        exp_code[2] = 5'h03;
        @(negedge clk);
        w1.valid = 1'b0;
        step_chk(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
